servo_pwm_out: RTL and testbench

Servo PWM output stage, directly downstream of the per-axis servo position calculator. Its `pwm_thres_in` input carries that stage's 15-bit pulse-width command in microseconds, which is written on the camera vsync domain. The block produces a fixed-period servo pulse in the system clock domain. It captures the command only when it is stable, clamps it to the mechanical limits, applies a per-period slew limit, and changes pulse width only on period boundaries.

---
 rtl/servo_pwm_out.sv | 214 +++++++++++++++++++++
 tb/tb_servo_pwm_out.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_out.sv
// Servo PWM output stage.
// Turns a pulse-width command in microseconds, written from an unrelated
// clock domain, into a fixed-period servo pulse on the system clock. The
// command is captured only once it has settled and is then clamped to the
// mechanical limits. Pulse width changes only at a period boundary, and by
// no more than a fixed slew step per period.

`timescale 1ns/1ps

module servo_pwm_out #(
  parameter int CLK_DIV    = 100,    // system clocks per microsecond tick
  parameter int PERIOD_US  = 20000,  // PWM period in microseconds
  parameter int MIN_US     = 800,    // lower pulse-width limit
  parameter int MAX_US     = 2150,   // upper pulse-width limit
  parameter int DEFAULT_US = 1500,   // reset / centre pulse width
  parameter int SLEW_US    = 60      // max change of active_us per period
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable_in,
  input  logic [14:0] pwm_thres_in,
  output logic        pwm_out,
  output logic [14:0] active_us,
  output logic        period_start,
  output logic        clamped
);

  // ---------------------------------------------------------------------------
  // Derived constants, all sized to the datapaths they are compared against.
  // A divider of 1 still needs a 1-bit prescaler that simply ticks every cycle.
  // ---------------------------------------------------------------------------
  localparam int                PRE_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE    = PRE_W'(1);
  localparam logic [14:0]       US_LAST    = 15'(PERIOD_US - 1);
  localparam logic [14:0]       MIN_V      = 15'(MIN_US);
  localparam logic [14:0]       MAX_V      = 15'(MAX_US);
  localparam logic [14:0]       DEF_V      = 15'(DEFAULT_US);
  localparam logic signed [15:0] SLEW_POS  = 16'(SLEW_US);
  localparam logic signed [15:0] SLEW_NEG  = -SLEW_POS;

  // Output state machine encoding.
  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt_q,      pre_cnt_d;
  logic [14:0]      us_cnt_q,       us_cnt_d;
  logic             period_start_q, period_start_d;
  logic [14:0]      samp0_q,        samp0_d;
  logic [14:0]      samp1_q,        samp1_d;
  logic [14:0]      stable_q,       stable_d;
  logic [14:0]      active_q,       active_d;
  logic             clamped_q,      clamped_d;
  logic [1:0]       state_q,        state_d;
  logic             pwm_q,          pwm_d;

  // Combinational helpers.
  logic               us_tick;
  logic               boundary;
  logic [14:0]        target;
  logic               clamp_hit;
  logic signed [15:0] diff;
  logic signed [15:0] slew_step;
  logic signed [15:0] slewed;
  logic               unused_slewed_msb;

  // Prescaler and period counter; the period boundary is the us_cnt wrap.
  always_comb begin
    us_tick        = (pre_cnt_q == PRE_LAST);
    pre_cnt_d      = us_tick ? '0 : (pre_cnt_q + PRE_ONE);
    boundary       = us_tick && (us_cnt_q == US_LAST);
    us_cnt_d       = us_cnt_q;
    if (us_tick) begin
      us_cnt_d = (us_cnt_q == US_LAST) ? 15'd0 : (us_cnt_q + 15'd1);
    end
    period_start_d = boundary;
  end

  // Two-stage capture of the foreign-domain command. A value is accepted only
  // when both stages agree, so a word caught half-way through a multi-bit
  // change (the two stages differ) never reaches stable_q.
  always_comb begin
    samp0_d  = pwm_thres_in;
    samp1_d  = samp0_q;
    stable_d = (samp0_q == samp1_q) ? samp1_q : stable_q;
  end

  // Clamp the settled command, then move active_us toward it by at most one
  // slew step. Both results are only committed on a period boundary. Because
  // active_us starts inside the limits and each step never overshoots the
  // clamped target, the result always stays within [MIN_US, MAX_US].
  always_comb begin
    target    = stable_q;
    clamp_hit = 1'b0;
    if (stable_q < MIN_V) begin
      target    = MIN_V;
      clamp_hit = 1'b1;
    end else if (stable_q > MAX_V) begin
      target    = MAX_V;
      clamp_hit = 1'b1;
    end

    diff = $signed({1'b0, target}) - $signed({1'b0, active_q});
    if (diff > SLEW_POS) begin
      slew_step = SLEW_POS;
    end else if (diff < SLEW_NEG) begin
      slew_step = SLEW_NEG;
    end else begin
      slew_step = diff;
    end

    // The sum is always a legal non-negative pulse width, so bit 15 is zero.
    slewed            = $signed({1'b0, active_q}) + slew_step;
    unused_slewed_msb = slewed[15];

    active_d  = boundary ? slewed[14:0] : active_q;
    clamped_d = boundary ? clamp_hit    : clamped_q;
  end

  // Enable state machine plus the registered pin value. ARMED waits for a
  // boundary so the first pulse after enabling is always full width; RUN
  // drops out immediately when enable falls, truncating any pulse in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: begin
        if (enable_in) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!enable_in) begin
          state_d = ST_DISABLED;
        end else if (boundary) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable_in) begin
          state_d = ST_DISABLED;
        end
      end
      default: begin
        state_d = ST_DISABLED;
      end
    endcase

    pwm_d = (state_q == ST_RUN) && (us_cnt_q < active_q);
  end

  // Timebase registers: prescaler, microsecond counter, boundary strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt_q      <= '0;
      us_cnt_q       <= 15'd0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      us_cnt_q       <= us_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  // Command capture registers; they come up holding the centre position.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      samp0_q  <= DEF_V;
      samp1_q  <= DEF_V;
      stable_q <= DEF_V;
    end else begin
      samp0_q  <= samp0_d;
      samp1_q  <= samp1_d;
      stable_q <= stable_d;
    end
  end

  // Pulse width in use and the clamp flag of the last loaded target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q  <= DEF_V;
      clamped_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      clamped_q <= clamped_d;
    end
  end

  // State and output pin; reset forces the pin low without waiting for clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_DISABLED;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign active_us    = active_q;
  assign period_start = period_start_q;
  assign clamped      = clamped_q;

  // The pulse must always end inside its period; a MAX_US at or beyond the
  // period length is a parameterisation error and stops simulation.
  assert property (@(posedge clk) disable iff (!resetn)
                   (MAX_US < PERIOD_US) && (active_q <= US_LAST))
    else $fatal(1, "servo_pwm_out: pulse width reaches the PWM period");

endmodule

// File: tb/tb_servo_pwm_out.sv
// Self-checking bench for servo_pwm_out with a small timebase. Expected pulse
// widths, clamp flags and boundary timing come from a plain arithmetic model
// of the clamp/slew rules, applied once per observed period boundary.

`timescale 1ns/1ps

module tb_servo_pwm_out;

  localparam int CLK_DIV     = 2;
  localparam int PERIOD_US   = 100;
  localparam int MIN_US      = 20;
  localparam int MAX_US      = 80;
  localparam int DEFAULT_US  = 50;
  localparam int SLEW_US     = 10;
  localparam int PERIOD_CLKS = CLK_DIV * PERIOD_US;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable_in;
  logic [14:0] pwm_thres_in;
  logic        pwm_out;
  logic [14:0] active_us;
  logic        period_start;
  logic        clamped;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_ps = 0;
  int   exp_active = DEFAULT_US;
  logic exp_clamped = 1'b0;
  int   cur_cmd = DEFAULT_US;

  servo_pwm_out #(
    .CLK_DIV    (CLK_DIV),
    .PERIOD_US  (PERIOD_US),
    .MIN_US     (MIN_US),
    .MAX_US     (MAX_US),
    .DEFAULT_US (DEFAULT_US),
    .SLEW_US    (SLEW_US)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable_in    (enable_in),
    .pwm_thres_in (pwm_thres_in),
    .pwm_out      (pwm_out),
    .active_us    (active_us),
    .period_start (period_start),
    .clamped      (clamped)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: clamp the command, limit the move to one slew step.
  task automatic model_boundary(input int cmd);
    int tgt;
    int d;
    if (cmd < MIN_US)      tgt = MIN_US;
    else if (cmd > MAX_US) tgt = MAX_US;
    else                   tgt = cmd;
    exp_clamped = (cmd < MIN_US) || (cmd > MAX_US);
    d = tgt - exp_active;
    if (d > SLEW_US)       d = SLEW_US;
    else if (d < -SLEW_US) d = -SLEW_US;
    exp_active = exp_active + d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_cmd(input int cmd);
    cur_cmd      = cmd;
    pwm_thres_in = 15'(cmd);
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn      = 1'b1;
    cyc         = 0;
    last_ps     = 0;
    exp_active  = DEFAULT_US;
    exp_clamped = 1'b0;
  endtask

  // Step until period_start (bounded); report spacing and pwm high samples.
  task automatic wait_boundary(input bit toggle, output int gap, output int hi);
    int n;
    bit phase;
    n = 0;
    hi = 0;
    phase = 1'b0;
    do begin
      if (toggle) begin
        pwm_thres_in = phase ? 15'd60 : 15'd40;
        phase = ~phase;
      end
      step();
      n++;
      if (pwm_out === 1'b1) hi++;
    end while (period_start !== 1'b1 && n < 2 * PERIOD_CLKS);
    gap = cyc - last_ps;
    last_ps = cyc;
    if (period_start === 1'b1) model_boundary(cur_cmd);
    $display("boundary cyc=%0d gap=%0d cmd=%0d active_us=%0d clamped=%0b",
             cyc, gap, cur_cmd, active_us, clamped);
  endtask

  // Called right after a boundary sample: count consecutive high samples
  // starting one clock later.
  task automatic measure_high(output int n);
    n = 0;
    step();
    while (pwm_out === 1'b1 && n < 2 * PERIOD_CLKS) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int gap, hi, n;
    resetn = 1'b0;
    enable_in = 1'b1;
    set_cmd(DEFAULT_US);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm: got %0b want 0", pwm_out); end
    n_cmp++; if (active_us !== 15'(DEFAULT_US)) begin n_bad++; $display("FAIL reset_active: got %0d want %0d", active_us, DEFAULT_US); end
    n_cmp++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL reset_period_start: got %0b want 0", period_start); end
    n_cmp++; if (clamped !== 1'b0) begin n_bad++; $display("FAIL reset_clamped: got %0b want 0", clamped); end
    release_reset();
    wait_boundary(1'b0, gap, hi);
    n_cmp++; if (gap !== PERIOD_CLKS) begin n_bad++; $display("FAIL first_boundary: got clock %0d want %0d", gap, PERIOD_CLKS); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL pwm_at_boundary: got %0b want 0", pwm_out); end
    measure_high(n);
    n_cmp++; if (n !== exp_active * CLK_DIV) begin n_bad++; $display("FAIL first_pulse_width: got %0d want %0d", n, exp_active * CLK_DIV); end
    wait_boundary(1'b0, gap, hi);
    n_cmp++; if (gap !== PERIOD_CLKS) begin n_bad++; $display("FAIL period_length: got %0d want %0d", gap, PERIOD_CLKS); end
    n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL reset_hold_active: got %0d want %0d", active_us, exp_active); end
  endtask

  task automatic test_slew();
    int gap, hi, n;
    set_cmd(75);
    for (int i = 0; i < 3; i++) begin
      wait_boundary(1'b0, gap, hi);
      n_cmp++; if (gap !== PERIOD_CLKS) begin n_bad++; $display("FAIL slew_period[%0d]: got %0d want %0d", i, gap, PERIOD_CLKS); end
      n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL slew_active[%0d]: got %0d want %0d", i, active_us, exp_active); end
      n_cmp++; if (clamped !== exp_clamped) begin n_bad++; $display("FAIL slew_clamped[%0d]: got %0b want %0b", i, clamped, exp_clamped); end
      measure_high(n);
      n_cmp++; if (n !== exp_active * CLK_DIV) begin n_bad++; $display("FAIL slew_width[%0d]: got %0d want %0d", i, n, exp_active * CLK_DIV); end
    end
  endtask

  task automatic test_clamp();
    int gap, hi;
    set_cmd(5);
    for (int i = 0; i < 7; i++) begin
      wait_boundary(1'b0, gap, hi);
      n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL clamp_low_active[%0d]: got %0d want %0d", i, active_us, exp_active); end
      n_cmp++; if (clamped !== exp_clamped) begin n_bad++; $display("FAIL clamp_low_flag[%0d]: got %0b want %0b", i, clamped, exp_clamped); end
    end
    n_cmp++; if (active_us !== 15'(MIN_US)) begin n_bad++; $display("FAIL clamp_low_final: got %0d want %0d", active_us, MIN_US); end
    set_cmd(30000);
    for (int i = 0; i < 7; i++) begin
      wait_boundary(1'b0, gap, hi);
      n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL clamp_high_active[%0d]: got %0d want %0d", i, active_us, exp_active); end
      n_cmp++; if (clamped !== exp_clamped) begin n_bad++; $display("FAIL clamp_high_flag[%0d]: got %0b want %0b", i, clamped, exp_clamped); end
    end
    n_cmp++; if (active_us !== 15'(MAX_US)) begin n_bad++; $display("FAIL clamp_high_final: got %0d want %0d", active_us, MAX_US); end
  endtask

  task automatic test_random();
    int gap, hi, n;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) set_cmd(int'($urandom_range(0, 32767)));
      else                           set_cmd(int'($urandom_range(0, 100)));
      wait_boundary(1'b0, gap, hi);
      n_cmp++; if (gap !== PERIOD_CLKS) begin n_bad++; $display("FAIL rand_period[%0d]: got %0d want %0d", i, gap, PERIOD_CLKS); end
      n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL rand_active[%0d]: cmd %0d got %0d want %0d", i, cur_cmd, active_us, exp_active); end
      n_cmp++; if (clamped !== exp_clamped) begin n_bad++; $display("FAIL rand_clamped[%0d]: cmd %0d got %0b want %0b", i, cur_cmd, clamped, exp_clamped); end
      measure_high(n);
      n_cmp++; if (n !== exp_active * CLK_DIV) begin n_bad++; $display("FAIL rand_width[%0d]: got %0d want %0d", i, n, exp_active * CLK_DIV); end
    end
  endtask

  task automatic test_skew();
    int gap, hi, i;
    set_cmd(50);
    i = 0;
    do begin
      wait_boundary(1'b0, gap, hi);
      i++;
    end while (exp_active != 50 && i < 10);
    n_cmp++; if (active_us !== 15'd50) begin n_bad++; $display("FAIL skew_setup: got %0d want 50", active_us); end
    for (int k = 0; k < 2; k++) begin
      wait_boundary(1'b1, gap, hi);
      n_cmp++; if (active_us !== 15'd50) begin n_bad++; $display("FAIL skew_active[%0d]: got %0d want 50", k, active_us); end
      n_cmp++; if (clamped !== 1'b0) begin n_bad++; $display("FAIL skew_clamped[%0d]: got %0b want 0", k, clamped); end
    end
    pwm_thres_in = 15'(cur_cmd);
  endtask

  task automatic test_enable();
    int gap, hi, n;
    wait_boundary(1'b0, gap, hi);
    repeat (10) step();
    n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL en_mid_pulse: got %0b want 1", pwm_out); end
    enable_in = 1'b0;
    step();
    step();
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL en_fall_low: got %0b want 0", pwm_out); end
    wait_boundary(1'b0, gap, hi);
    n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL en_disabled_quiet: got %0d high clocks want 0", hi); end
    n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL en_disabled_active: got %0d want %0d", active_us, exp_active); end
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (pwm_out === 1'b1) hi++;
    end
    enable_in = 1'b1;
    wait_boundary(1'b0, gap, n);
    hi = hi + n;
    n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL en_armed_quiet: got %0d high clocks want 0", hi); end
    n_cmp++; if (gap !== PERIOD_CLKS) begin n_bad++; $display("FAIL en_period: got %0d want %0d", gap, PERIOD_CLKS); end
    measure_high(n);
    n_cmp++; if (n !== exp_active * CLK_DIV) begin n_bad++; $display("FAIL en_rearm_width: got %0d want %0d", n, exp_active * CLK_DIV); end
  endtask

  task automatic test_async_reset();
    int gap, hi, n;
    resetn = 1'b0;
    enable_in = 1'b1;
    set_cmd(75);
    step();
    step();
    release_reset();
    wait_boundary(1'b0, gap, hi);
    n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL ar_first_active: got %0d want %0d", active_us, exp_active); end
    repeat (50) step();
    n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL ar_mid_pulse: got %0b at clock %0d want 1", pwm_out, cyc); end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL ar_pwm_drop: got %0b want 0", pwm_out); end
    n_cmp++; if (active_us !== 15'(DEFAULT_US)) begin n_bad++; $display("FAIL ar_active: got %0d want %0d", active_us, DEFAULT_US); end
    n_cmp++; if (clamped !== 1'b0) begin n_bad++; $display("FAIL ar_clamped: got %0b want 0", clamped); end
    release_reset();
    wait_boundary(1'b0, gap, hi);
    n_cmp++; if (gap !== PERIOD_CLKS) begin n_bad++; $display("FAIL ar_next_boundary: got %0d want %0d", gap, PERIOD_CLKS); end
    n_cmp++; if (active_us !== 15'(exp_active)) begin n_bad++; $display("FAIL ar_post_active: got %0d want %0d", active_us, exp_active); end
    measure_high(n);
    n_cmp++; if (n !== exp_active * CLK_DIV) begin n_bad++; $display("FAIL ar_post_width: got %0d want %0d", n, exp_active * CLK_DIV); end
  endtask

  initial begin
    resetn = 1'b0;
    enable_in = 1'b0;
    pwm_thres_in = 15'(DEFAULT_US);
    test_reset();
    test_slew();
    test_clamp();
    test_random();
    test_skew();
    test_enable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
